alu_share_arbiter: RTL and testbench

Sequencer and arbiter that time-shares the single execute-stage ALU between two requesters: port A (integer pipeline) and port B (address/CSR helper). It accepts one operation at a time through a valid/ready handshake, drives the ALU's `in1`/`in2`/`alu_op` inputs from registered operands, and captures the result. It returns the result to the owning requester through a held response handshake. It sits beside the ALU; the ALU stays purely combinational and is instantiated by the parent.

---
 rtl/alu_share_arbiter_if.sv | 48 ++++
 rtl/alu_share_arbiter.sv | 132 +++++++++++++
 tb/tb_alu_share_arbiter.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_share_arbiter_if.sv
// Requester and ALU-side signals of alu_share_arbiter.
// The slave modport is the arbiter; the master modport is the requesters plus the parent's ALU.
interface alu_share_arbiter_if #(
  parameter int XLEN = 32,
  parameter int OPW  = 4
);
  logic            req_valid_a;
  logic            req_ready_a;
  logic [OPW-1:0]  req_op_a;
  logic [XLEN-1:0] req_in1_a;
  logic [XLEN-1:0] req_in2_a;
  logic            rsp_valid_a;
  logic            rsp_ready_a;
  logic [XLEN-1:0] rsp_data_a;

  logic            req_valid_b;
  logic            req_ready_b;
  logic [OPW-1:0]  req_op_b;
  logic [XLEN-1:0] req_in1_b;
  logic [XLEN-1:0] req_in2_b;
  logic            rsp_valid_b;
  logic            rsp_ready_b;
  logic [XLEN-1:0] rsp_data_b;

  logic [XLEN-1:0] alu_in1;
  logic [XLEN-1:0] alu_in2;
  logic [OPW-1:0]  alu_op;
  logic [XLEN-1:0] alu_out;
  logic            busy;

  modport slave (
    input  req_valid_a, req_op_a, req_in1_a, req_in2_a, rsp_ready_a,
    output req_ready_a, rsp_valid_a, rsp_data_a,
    input  req_valid_b, req_op_b, req_in1_b, req_in2_b, rsp_ready_b,
    output req_ready_b, rsp_valid_b, rsp_data_b,
    output alu_in1, alu_in2, alu_op, busy,
    input  alu_out
  );

  modport master (
    output req_valid_a, req_op_a, req_in1_a, req_in2_a, rsp_ready_a,
    input  req_ready_a, rsp_valid_a, rsp_data_a,
    output req_valid_b, req_op_b, req_in1_b, req_in2_b, rsp_ready_b,
    input  req_ready_b, rsp_valid_b, rsp_data_b,
    input  alu_in1, alu_in2, alu_op, busy,
    output alu_out
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Time-shares one combinational ALU between ports A and B; accept -> EXEC -> RESP, result 2 cycles after accept.
// Held response: rsp_valid/rsp_data stay put until the owner's rsp_ready; ALU_ARB_RR_EN selects round-robin over fixed A priority.
module alu_share_arbiter #(
  parameter int XLEN = 32,
  parameter int OPW  = 4
) (
  input logic               clk,
  input logic               rst,
  alu_share_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  state_t          state_q, state_d;
  logic            owner_q, owner_d;
  logic [OPW-1:0]  op_q, op_d;
  logic [XLEN-1:0] in1_q, in1_d;
  logic [XLEN-1:0] in2_q, in2_d;
  logic [XLEN-1:0] res_q, res_d;

  logic grant_a, grant_b;
  logic acc_a, acc_b;

`ifdef ALU_ARB_RR_EN
  logic last_grant_q, last_grant_d;

  // Under contention the port not served last wins; a lone requester always wins.
  always_comb begin
    grant_a = bus.req_valid_a & (~bus.req_valid_b | (last_grant_q == PORT_B));
    grant_b = bus.req_valid_b & (~bus.req_valid_a | (last_grant_q == PORT_A));
  end

  always_comb begin
    last_grant_d = last_grant_q;
    if (acc_a) begin
      last_grant_d = PORT_A;
    end else if (acc_b) begin
      last_grant_d = PORT_B;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= PORT_B;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`else
  always_comb begin
    grant_a = bus.req_valid_a;
    grant_b = bus.req_valid_b & ~bus.req_valid_a;
  end
`endif

  assign acc_a = (state_q == IDLE) & grant_a & ~rst;
  assign acc_b = (state_q == IDLE) & grant_b & ~rst;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    op_d    = op_q;
    in1_d   = in1_q;
    in2_d   = in2_q;
    res_d   = res_q;
    case (state_q)
      IDLE: begin
        if (acc_a) begin
          owner_d = PORT_A;
          op_d    = bus.req_op_a;
          in1_d   = bus.req_in1_a;
          in2_d   = bus.req_in2_a;
          state_d = EXEC;
        end else if (acc_b) begin
          owner_d = PORT_B;
          op_d    = bus.req_op_b;
          in1_d   = bus.req_in1_b;
          in2_d   = bus.req_in2_b;
          state_d = EXEC;
        end
      end
      EXEC: begin
        res_d   = bus.alu_out;
        state_d = RESP;
      end
      RESP: begin
        // Only the owner's consume matters; the other port's rsp_ready is ignored.
        if ((owner_q == PORT_A) ? bus.rsp_ready_a : bus.rsp_ready_b) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= PORT_A;
      op_q    <= '0;
      in1_q   <= '0;
      in2_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      op_q    <= op_d;
      in1_q   <= in1_d;
      in2_q   <= in2_d;
      res_q   <= res_d;
    end
  end

  assign bus.req_ready_a = acc_a;
  assign bus.req_ready_b = acc_b;
  assign bus.rsp_valid_a = (state_q == RESP) & (owner_q == PORT_A);
  assign bus.rsp_valid_b = (state_q == RESP) & (owner_q == PORT_B);
  assign bus.rsp_data_a  = res_q;
  assign bus.rsp_data_b  = res_q;
  assign bus.alu_in1     = in1_q;
  assign bus.alu_in2     = in2_q;
  assign bus.alu_op      = op_q;
  assign bus.busy        = (state_q != IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: directed vector table plus back-pressure, reset and contention sequences.
module tb_alu_share_arbiter;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  alu_share_arbiter_if #(.XLEN(32), .OPW(4)) bus ();

  alu_share_arbiter #(.XLEN(32), .OPW(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in for the parent's combinational ALU.
  always_comb begin
    case (bus.alu_op)
      4'd0:    bus.alu_out = bus.alu_in1 + bus.alu_in2;
      4'd1:    bus.alu_out = bus.alu_in1 - bus.alu_in2;
      4'd2:    bus.alu_out = bus.alu_in1 & bus.alu_in2;
      4'd3:    bus.alu_out = bus.alu_in1 | bus.alu_in2;
      4'd4:    bus.alu_out = bus.alu_in1 ^ bus.alu_in2;
      4'd5:    bus.alu_out = {31'd0, $signed(bus.alu_in1) < $signed(bus.alu_in2)};
      4'd6:    bus.alu_out = {31'd0, bus.alu_in1 < bus.alu_in2};
      4'd7:    bus.alu_out = bus.alu_in1 << bus.alu_in2[4:0];
      4'd8:    bus.alu_out = bus.alu_in1 >> bus.alu_in2[4:0];
      4'd9:    bus.alu_out = $unsigned($signed(bus.alu_in1) >>> bus.alu_in2[4:0]);
      4'd10:   bus.alu_out = bus.alu_in1;
      4'd11:   bus.alu_out = bus.alu_in2;
      default: bus.alu_out = 32'd0;
    endcase
  end

  typedef struct {
    logic        port;
    logic [3:0]  op;
    logic [31:0] in1;
    logic [31:0] in2;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_req(input logic port, input logic [3:0] op, input logic [31:0] a1, input logic [31:0] a2);
    if (port == 1'b0) begin
      bus.req_valid_a = 1'b1; bus.req_op_a = op; bus.req_in1_a = a1; bus.req_in2_a = a2;
    end else begin
      bus.req_valid_b = 1'b1; bus.req_op_b = op; bus.req_in1_b = a1; bus.req_in2_b = a2;
    end
  endtask

  task automatic run_op(input logic port, input logic [3:0] op, input logic [31:0] a1,
                        input logic [31:0] a2, input logic [31:0] expv);
    @(negedge clk);
    drive_req(port, op, a1, a2);
    bus.rsp_ready_a = 1'b1;
    bus.rsp_ready_b = 1'b1;
    #1;
    chk("req_ready_owner", port ? bus.req_ready_b : bus.req_ready_a, 32'd1);
    chk("req_ready_other", port ? bus.req_ready_a : bus.req_ready_b, 32'd0);
    @(posedge clk);
    #1;
    bus.req_valid_a = 1'b0;
    bus.req_valid_b = 1'b0;
    @(negedge clk);
    #1;
    chk("exec_busy", bus.busy, 32'd1);
    chk("exec_rsp_valid", port ? bus.rsp_valid_b : bus.rsp_valid_a, 32'd0);
    chk("exec_alu_op", bus.alu_op, op);
    chk("exec_alu_in1", bus.alu_in1, a1);
    chk("exec_alu_in2", bus.alu_in2, a2);
    @(negedge clk);
    #1;
    chk("resp_valid_owner", port ? bus.rsp_valid_b : bus.rsp_valid_a, 32'd1);
    chk("resp_valid_other", port ? bus.rsp_valid_a : bus.rsp_valid_b, 32'd0);
    chk("resp_data_a", bus.rsp_data_a, expv);
    chk("resp_data_b", bus.rsp_data_b, expv);
    @(negedge clk);
    #1;
    chk("after_busy", bus.busy, 32'd0);
    chk("after_rsp_valid", port ? bus.rsp_valid_b : bus.rsp_valid_a, 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, bus.busy, 32'd0);
    chk({tag, "_req_ready_a"}, bus.req_ready_a, 32'd0);
    chk({tag, "_req_ready_b"}, bus.req_ready_b, 32'd0);
    chk({tag, "_rsp_valid_a"}, bus.rsp_valid_a, 32'd0);
    chk({tag, "_rsp_valid_b"}, bus.rsp_valid_b, 32'd0);
    chk({tag, "_rsp_data_a"}, bus.rsp_data_a, 32'd0);
    chk({tag, "_rsp_data_b"}, bus.rsp_data_b, 32'd0);
    chk({tag, "_alu_in1"}, bus.alu_in1, 32'd0);
    chk({tag, "_alu_in2"}, bus.alu_in2, 32'd0);
    chk({tag, "_alu_op"}, bus.alu_op, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time %0t required below 100000", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic exp_grant_b [4];
    errors = 0;
    checks = 0;

    vecs[0] = '{1'b0, 4'd0,  32'd5,          32'd7,        32'd12};
    vecs[1] = '{1'b1, 4'd5,  32'hFFFF_FFFF,  32'd1,        32'd1};
    vecs[2] = '{1'b1, 4'd9,  32'h8000_0000,  32'd4,        32'hF800_0000};
    vecs[3] = '{1'b0, 4'd1,  32'd10,         32'd3,        32'd7};
    vecs[4] = '{1'b1, 4'd3,  32'h0000_000F,  32'h0000_00F0, 32'h0000_00FF};
    vecs[5] = '{1'b0, 4'd12, 32'd9,          32'd9,        32'd0};
    vecs[6] = '{1'b0, 4'd0,  32'hFFFF_FFFF,  32'd1,        32'd0};
    vecs[7] = '{1'b1, 4'd11, 32'hDEAD_BEEF,  32'h0000_1234, 32'h0000_1234};
    vecs[8] = '{1'b1, 4'd15, 32'd1,          32'd2,        32'd0};

    rst = 1'b0;
    bus.req_valid_a = 1'b0; bus.req_op_a = '0; bus.req_in1_a = '0; bus.req_in2_a = '0;
    bus.req_valid_b = 1'b0; bus.req_op_b = '0; bus.req_in1_b = '0; bus.req_in2_b = '0;
    bus.rsp_ready_a = 1'b0; bus.rsp_ready_b = 1'b0;

    // Reset state, with A requesting to show ready is forced low.
    #2 rst = 1'b1;
    bus.req_valid_a = 1'b1;
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;
    bus.req_valid_a = 1'b0;

    for (int i = 0; i < 9; i++) begin
      run_op(vecs[i].port, vecs[i].op, vecs[i].in1, vecs[i].in2, vecs[i].exp);
    end

    // Back-pressure on B with A waiting behind it.
    @(negedge clk);
    drive_req(1'b1, 4'd3, 32'h0F, 32'hF0);
    bus.rsp_ready_b = 1'b0;
    bus.rsp_ready_a = 1'b1;
    #1;
    chk("bp_req_ready_b", bus.req_ready_b, 32'd1);
    @(posedge clk);
    #1;
    bus.req_valid_b = 1'b0;
    drive_req(1'b0, 4'd0, 32'd1, 32'd2);
    @(negedge clk);
    #1;
    chk("bp_exec_ready_a", bus.req_ready_a, 32'd0);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      #1;
      chk("bp_rsp_valid_b", bus.rsp_valid_b, 32'd1);
      chk("bp_rsp_data_b", bus.rsp_data_b, 32'hFF);
      chk("bp_rsp_valid_a", bus.rsp_valid_a, 32'd0);
      chk("bp_req_ready_a", bus.req_ready_a, 32'd0);
    end
    bus.rsp_ready_b = 1'b1;
    #1;
    chk("bp_consume_ready_a", bus.req_ready_a, 32'd0);
    @(negedge clk);
    #1;
    chk("bp_rsp_valid_b_gone", bus.rsp_valid_b, 32'd0);
    chk("bp_grant_a_after", bus.req_ready_a, 32'd1);
    @(posedge clk);
    #1;
    bus.req_valid_a = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("bp_a_rsp_valid", bus.rsp_valid_a, 32'd1);
    chk("bp_a_rsp_data", bus.rsp_data_a, 32'd3);
    @(negedge clk);

    // Reset while EXEC: operation discarded, outputs cleared asynchronously.
    @(negedge clk);
    drive_req(1'b0, 4'd0, 32'd5, 32'd6);
    @(posedge clk);
    #1;
    bus.req_valid_a = 1'b0;
    chk("rst_pre_busy", bus.busy, 32'd1);
    chk("rst_pre_alu_in1", bus.alu_in1, 32'd5);
    #1 rst = 1'b1;
    #1;
    check_reset_outputs("rst_mid");
    drive_req(1'b0, 4'd1, 32'd10, 32'd3);
    #1;
    chk("rst_mid_forced_ready_a", bus.req_ready_a, 32'd0);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      #1;
      chk("rst_hold_rsp_valid_a", bus.rsp_valid_a, 32'd0);
      chk("rst_hold_rsp_valid_b", bus.rsp_valid_b, 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    bus.req_valid_a = 1'b0;
    #1;
    chk("rst_rel_rsp_valid_a", bus.rsp_valid_a, 32'd0);
    chk("rst_rel_busy", bus.busy, 32'd0);
    run_op(1'b0, 4'd1, 32'd10, 32'd3, 32'd7);

    // Contention from reset: both ports valid, owners identified by their results.
`ifdef ALU_ARB_RR_EN
    exp_grant_b = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
    exp_grant_b = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
    @(negedge clk);
    rst = 1'b1;
    drive_req(1'b0, 4'd0, 32'd1, 32'd1);
    drive_req(1'b1, 4'd0, 32'd100, 32'd1);
    bus.rsp_ready_a = 1'b1;
    bus.rsp_ready_b = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (c % 3 == 0) begin
        chk("cont_ready_a", bus.req_ready_a, {31'd0, ~exp_grant_b[c/3]});
        chk("cont_ready_b", bus.req_ready_b, {31'd0, exp_grant_b[c/3]});
      end else if (c % 3 == 1) begin
        chk("cont_exec_ready_a", bus.req_ready_a, 32'd0);
        chk("cont_exec_ready_b", bus.req_ready_b, 32'd0);
      end else begin
        chk("cont_rsp_valid_a", bus.rsp_valid_a, {31'd0, ~exp_grant_b[c/3]});
        chk("cont_rsp_valid_b", bus.rsp_valid_b, {31'd0, exp_grant_b[c/3]});
        chk("cont_rsp_data", bus.rsp_data_a, exp_grant_b[c/3] ? 32'd101 : 32'd2);
      end
      if (c == 11) bus.req_valid_a = 1'b0;
      @(negedge clk);
    end
    #1;
    chk("lone_b_ready_b", bus.req_ready_b, 32'd1);
    chk("lone_b_ready_a", bus.req_ready_a, 32'd0);
    @(posedge clk);
    #1;
    bus.req_valid_b = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("lone_b_rsp_valid", bus.rsp_valid_b, 32'd1);
    chk("lone_b_rsp_data", bus.rsp_data_b, 32'd101);
    @(negedge clk);
    #1;
    chk("final_busy", bus.busy, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
